add_arbiter: RTL

ADD_ARBITER -- requirements
Module: add_arbiter

---
 rtl/add_arbiter.sv | 128 ++++++++++++
 1 files changed

// File: rtl/add_arbiter.sv
// ============================================================================
// Module   : add_arbiter
// Purpose  : Two requesters share one N-bit ripple-carry adder through an
//            IDLE/EXEC/RESP handshake FSM. Define ADD_ARBITER_RR_EN for
//            round-robin tie-breaking; otherwise requester 0 has fixed priority.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module add_arbiter #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req0_valid,
  input  logic [N-1:0] req0_a,
  input  logic [N-1:0] req0_b,
  output logic         req0_ready,
  input  logic         req1_valid,
  input  logic [N-1:0] req1_a,
  input  logic [N-1:0] req1_b,
  output logic         req1_ready,
  output logic         resp0_valid,
  input  logic         resp0_ready,
  output logic         resp1_valid,
  input  logic         resp1_ready,
  output logic [N:0]   resp_sum,
  output logic         busy
);

  localparam logic [1:0] c_IDLE = 2'd0;
  localparam logic [1:0] c_EXEC = 2'd1;
  localparam logic [1:0] c_RESP = 2'd2;

  logic [1:0]   r_state;
  logic [1:0]   w_next;
  logic [N-1:0] r_a;
  logic [N-1:0] r_b;
  logic         r_owner;
  logic [N:0]   r_sum;
  logic         w_prio1;
  logic         w_grant0;
  logic         w_grant1;
  logic         w_resp_done;
  logic [N:0]   w_carry;
  logic [N-1:0] w_sum_bits;

`ifdef ADD_ARBITER_RR_EN
  logic r_ptr;

  always_ff @(posedge clk) begin
    if (rst)
      r_ptr <= 1'b0;
    else if (w_resp_done)
      r_ptr <= ~r_ptr;
  end

  assign w_prio1 = r_ptr;
`else
  assign w_prio1 = 1'b0;
`endif

  // A lone requester always wins; the priority bit only settles ties.
  always_comb begin
    w_grant1 = 1'b0;
    w_grant0 = 1'b0;
    if (r_state == c_IDLE && !rst) begin
      w_grant1 = req1_valid && (!req0_valid || w_prio1);
      w_grant0 = req0_valid && !w_grant1;
    end
  end

  assign w_resp_done = (r_state == c_RESP) && (r_owner ? resp1_ready : resp0_ready);

  assign w_carry[0] = 1'b0;
  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_rca
      assign w_sum_bits[gi]  = r_a[gi] ^ r_b[gi] ^ w_carry[gi];
      assign w_carry[gi + 1] = (r_a[gi] & r_b[gi]) | (w_carry[gi] & (r_a[gi] ^ r_b[gi]));
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst)
      r_state <= c_IDLE;
    else
      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      c_IDLE:  if (w_grant0 || w_grant1) w_next = c_EXEC;
      c_EXEC:  w_next = c_RESP;
      c_RESP:  if (w_resp_done) w_next = c_IDLE;
      default: w_next = c_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_a     <= '0;
      r_b     <= '0;
      r_owner <= 1'b0;
      r_sum   <= '0;
    end else begin
      if (w_grant0 || w_grant1) begin
        r_a     <= w_grant1 ? req1_a : req0_a;
        r_b     <= w_grant1 ? req1_b : req0_b;
        r_owner <= w_grant1;
      end
      if (r_state == c_EXEC)
        r_sum <= {w_carry[N], w_sum_bits};
    end
  end

  always_comb begin
    req0_ready  = w_grant0;
    req1_ready  = w_grant1;
    resp0_valid = (r_state == c_RESP) && !r_owner;
    resp1_valid = (r_state == c_RESP) && r_owner;
    resp_sum    = r_sum;
    busy        = (r_state != c_IDLE);
  end

endmodule

`default_nettype wire
